cache_wr_ctrl: RTL and testbench
================================

// Module: cache_wr_ctrl
// PURPOSE
//  Write controller for the direct-mapped, write-through, no-write-allocate data cache.
//  Accepts one CPU write at a time and looks up the line in the synchronous data/tag array.
//  On a hit, merges the write into the line through an internal update_data instance and writes the line back.
//  Always forwards the word write to memory, then acknowledges the CPU.
// PARAMETERS
//  ADDR_WIDTH      32  CPU byte address width
//  INDEX_WIDTH     4   line index bits (16 lines)
//  OFFSET_WIDTH    3   byte offset in line; offset[2] selects the 32-bit half
//  CACHE_STR_WIDTH 64  line width in bits
//  TAG_WIDTH (localparam) = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
// PORTS
//  sys_clk        in   1                clock, rising edge
//  sys_rst_n      in   1                asynchronous reset, active low
//  sys_wr         in   1                CPU write request, held until sys_ack
//  sys_addr       in   ADDR_WIDTH       CPU byte address
//  sys_wdata      in   32               CPU write data
//  sys_bval       in   4                byte valids, bit n -> sys_wdata[8n+7:8n]
//  sys_ack        out  1                one-cycle completion pulse
//  cache_rd_en    out  1                array read strobe
//  cache_wr_en    out  1                array line write strobe
//  cache_index    out  INDEX_WIDTH      array line index
//  cache_rd_data  in   CACHE_STR_WIDTH  line data, valid one cycle after cache_rd_en
//  cache_rd_tag   in   TAG_WIDTH        stored tag, same timing as cache_rd_data
//  cache_rd_valid in   1                stored valid bit, same timing as cache_rd_data
//  cache_wr_data  out  CACHE_STR_WIDTH  merged line to write
//  mem_wr_req     out  1                memory write request, held until mem_ack
//  mem_addr       out  ADDR_WIDTH       word address {tag,index,offset[2],2'b00}
//  mem_wdata      out  32               latched write data
//  mem_bval       out  4                latched byte valids
//  mem_ack        in   1                memory accepted write (sampled while mem_wr_req)
// BEHAVIOUR
//  - FSM states: IDLE, LOOKUP, COMPARE, MEM_WR, DONE. Reset state is IDLE.
//  - Reset values: all outputs 0; address/data/bval latches cleared.
//  - IDLE: on sys_wr=1, latch sys_addr, sys_wdata and sys_bval.
//    - If sys_bval!=0, go to LOOKUP.
//    - If sys_bval==0, go directly to DONE: no array access, no memory write.
//  - sys_wr is sampled only in IDLE; CPU inputs are ignored in all other states.
//  - LOOKUP: cache_rd_en=1 and cache_index=latched index, both for exactly one cycle. Next state COMPARE.
//  - COMPARE: hit = cache_rd_valid && (cache_rd_tag == latched tag).
//    - On hit: cache_wr_en=1 for this one cycle, same index.
//      cache_wr_data = update_data(cache_rd_data, latched wdata, offset, bval).
//    - On miss: cache_wr_en stays 0 and the array is untouched.
//    - Next state MEM_WR in both cases.
//  - MEM_WR: mem_wr_req=1, registered, with mem_addr/mem_wdata/mem_bval stable.
//    - Stay in MEM_WR until mem_ack=1, then go to DONE.
//    - mem_ack outside MEM_WR is ignored.
//  - DONE: sys_ack=1 for one cycle, then IDLE. The CPU drops sys_wr on the edge where it sees sys_ack.
//  - Latency: with mem_ack already high in the first MEM_WR cycle, sys_ack is high in the 4th cycle after the accept edge.
//  - Each extra mem_ack wait cycle adds 1 cycle to that latency.
//  - mem_addr[1:0]=0 always. sys_addr[1:0] is ignored; byte selection comes from bval only.
//  - cache_rd_en and cache_wr_en are never high in the same cycle.
//  - At most one write is outstanding at any time.
//  - Asynchronous reset mid-operation forces IDLE immediately.
//    - mem_wr_req drops and no sys_ack is issued.
//    - Any array write already committed in COMPARE stands.
// CONFIGURATION
//  CACHE_WR_STATS_EN defined:
//  - Adds outputs stat_hit_cnt[15:0] and stat_miss_cnt[15:0].
//  - The matching counter increments once per COMPARE cycle; both saturate at 16'hFFFF.
//  - Both counters reset to 0.
//  - bval==0 writes are counted in neither.
//  CACHE_WR_STATS_EN not defined: the ports and counters do not exist, and all other behaviour is identical.
// TESTING
//  1. Hit, low half:
//     - line 5 = 64'h1111_2222_3333_4444, valid, tag matches.
//     - Write offset=0, wdata=32'hAABBCCDD, bval=4'b0011, mem_ack tied 1.
//     - Expect cache_wr_data = 64'h1111_2222_3333_CCDD, mem_bval=4'b0011, sys_ack in the 4th cycle.
//  2. Hit, high half: same line, offset=4, bval=4'b1000, wdata=32'hEE000000.
//     - Expect cache_wr_data = 64'hEE11_2222_3333_4444.
//  3. Miss (tag mismatch or valid=0): expect cache_wr_en never asserted and mem_wr_req asserted with the correct mem_addr.
//  4. Memory stall: hold mem_ack=0 for 5 cycles.
//     - Expect mem_wr_req and mem_* held stable throughout.
//     - Expect exactly one sys_ack, 9 cycles after accept.
//  5. bval=4'b0000:
//     - Expect no cache_rd_en, cache_wr_en or mem_wr_req.
//     - Expect sys_ack in the cycle after accept.
//  6. Assert sys_rst_n=0 while in MEM_WR: expect all outputs 0 immediately, no sys_ack, and a clean new write accepted afterwards.
//     - With CACHE_WR_STATS_EN defined, run 3 hits and 2 misses: expect hit count 3, miss count 2.

Source files
------------

// File: rtl/cache_wr_ctrl.sv
// Write-through, no-write-allocate write controller for the direct-mapped data cache.
// Optional hit/miss statistics counters are enabled by defining CACHE_WR_STATS_EN.

module update_data #(
   parameter int LINE_W = 64,
   parameter int WSEL_W = 1
) (
   input  logic [LINE_W-1:0] line,
   input  logic [31:0]       wdata,
   input  logic [WSEL_W-1:0] wsel,
   input  logic [3:0]        bval,
   output logic [LINE_W-1:0] merged
);
   for (genvar w = 0; w < LINE_W/32; w++) begin : g_word
      for (genvar b = 0; b < 4; b++) begin : g_byte
         assign merged[w*32+b*8 +: 8] = (wsel == WSEL_W'(w) && bval[b]) ? wdata[b*8 +: 8]
                                                                        : line[w*32+b*8 +: 8];
      end
   end
endmodule

module cache_wr_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int INDEX_WIDTH     = 4,
   parameter int OFFSET_WIDTH    = 3,
   parameter int CACHE_STR_WIDTH = 64
) (
   input  logic                                         sys_clk,
   input  logic                                         sys_rst_n,
   input  logic                                         sys_wr,
   input  logic [ADDR_WIDTH-1:0]                        sys_addr,
   input  logic [31:0]                                  sys_wdata,
   input  logic [3:0]                                   sys_bval,
   output logic                                         sys_ack,
   output logic                                         cache_rd_en,
   output logic                                         cache_wr_en,
   output logic [INDEX_WIDTH-1:0]                       cache_index,
   input  logic [CACHE_STR_WIDTH-1:0]                   cache_rd_data,
   input  logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH-1:0] cache_rd_tag,
   input  logic                                         cache_rd_valid,
   output logic [CACHE_STR_WIDTH-1:0]                   cache_wr_data,
   output logic                                         mem_wr_req,
   output logic [ADDR_WIDTH-1:0]                        mem_addr,
   output logic [31:0]                                  mem_wdata,
   output logic [3:0]                                   mem_bval,
`ifdef CACHE_WR_STATS_EN
   output logic [15:0]                                  stat_hit_cnt,
   output logic [15:0]                                  stat_miss_cnt,
`endif
   input  logic                                         mem_ack
);
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int TAG_LO    = OFFSET_WIDTH + INDEX_WIDTH;
   localparam int WSEL_W    = OFFSET_WIDTH - 2;

   typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, MEM_WR, DONE} state_t;

   state_t                      state_q, state_d;
   logic [ADDR_WIDTH-1:2]       addr_q;
   logic [31:0]                 wdata_q;
   logic [3:0]                  bval_q;
   logic                        accept, hit;
   logic [CACHE_STR_WIDTH-1:0]  merged;
   logic [TAG_WIDTH-1:0]        tag_q;
   logic [INDEX_WIDTH-1:0]      idx_q;
   logic [WSEL_W-1:0]           wsel_q;
   logic                        unused_addr_lsb;

   // Byte lanes come from bval only, so the two address LSBs are never stored.
   assign unused_addr_lsb = ^sys_addr[1:0];

   assign tag_q  = addr_q[ADDR_WIDTH-1:TAG_LO];
   assign idx_q  = addr_q[TAG_LO-1:OFFSET_WIDTH];
   assign wsel_q = addr_q[OFFSET_WIDTH-1:2];
   assign hit    = cache_rd_valid && (cache_rd_tag == tag_q);

   update_data #(.LINE_W(CACHE_STR_WIDTH), .WSEL_W(WSEL_W)) u_update (
      .line   (cache_rd_data),
      .wdata  (wdata_q),
      .wsel   (wsel_q),
      .bval   (bval_q),
      .merged (merged)
   );

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      sys_ack       = 1'b0;
      cache_rd_en   = 1'b0;
      cache_wr_en   = 1'b0;
      cache_index   = '0;
      cache_wr_data = '0;
      case (state_q)
         IDLE: if (sys_wr) begin
            accept  = 1'b1;
            state_d = (sys_bval != 4'b0000) ? LOOKUP : DONE;
         end
         LOOKUP: begin
            cache_rd_en = 1'b1;
            cache_index = idx_q;
            state_d     = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               cache_wr_en   = 1'b1;
               cache_index   = idx_q;
               cache_wr_data = merged;
            end
            state_d = MEM_WR;
         end
         MEM_WR:  if (mem_ack) state_d = DONE;
         DONE: begin
            sys_ack = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         mem_wr_req <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         bval_q     <= '0;
      end else begin
         state_q    <= state_d;
         mem_wr_req <= (state_d == MEM_WR);
         if (accept) begin
            addr_q  <= sys_addr[ADDR_WIDTH-1:2];
            wdata_q <= sys_wdata;
            bval_q  <= sys_bval;
         end
      end
   end

   assign mem_addr  = {addr_q, 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_bval  = bval_q;

`ifdef CACHE_WR_STATS_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stat_hit_cnt  <= '0;
         stat_miss_cnt <= '0;
      end else if (state_q == COMPARE) begin
         if (hit) begin
            if (stat_hit_cnt != 16'hFFFF) stat_hit_cnt <= stat_hit_cnt + 16'd1;
         end else if (stat_miss_cnt != 16'hFFFF) begin
            stat_miss_cnt <= stat_miss_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_wr_ctrl.sv
// Bench for cache_wr_ctrl: array/memory responder, cycle timeline model and directed writes.
// Define CACHE_WR_STATS_EN to also check the hit/miss counters.

module tb_cache_wr_ctrl;
   localparam int TW = 25;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          sys_wr = 1'b0;
   logic [31:0]   sys_addr = '0, sys_wdata = '0;
   logic [3:0]    sys_bval = '0;
   logic          sys_ack, cache_rd_en, cache_wr_en, mem_wr_req;
   logic [3:0]    cache_index;
   logic [63:0]   cache_rd_data = '0;
   logic [TW-1:0] cache_rd_tag = '0;
   logic          cache_rd_valid = 1'b0;
   logic [63:0]   cache_wr_data;
   logic [31:0]   mem_addr, mem_wdata;
   logic [3:0]    mem_bval;
   logic          mem_ack = 1'b1;
`ifdef CACHE_WR_STATS_EN
   logic [15:0]   stat_hit_cnt, stat_miss_cnt;
`endif

   always #5 clk = ~clk;

   cache_wr_ctrl dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .sys_wr(sys_wr), .sys_addr(sys_addr),
      .sys_wdata(sys_wdata), .sys_bval(sys_bval), .sys_ack(sys_ack),
      .cache_rd_en(cache_rd_en), .cache_wr_en(cache_wr_en), .cache_index(cache_index),
      .cache_rd_data(cache_rd_data), .cache_rd_tag(cache_rd_tag), .cache_rd_valid(cache_rd_valid),
      .cache_wr_data(cache_wr_data), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_bval(mem_bval),
`ifdef CACHE_WR_STATS_EN
      .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt),
`endif
      .mem_ack(mem_ack)
   );

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // synchronous tag/data array: contents owned by the main sequence
   logic [63:0]   arr_data [16];
   logic [TW-1:0] arr_tag  [16];
   logic          arr_val  [16];

   always @(posedge clk) begin
      if (cache_rd_en) begin
         cache_rd_data  <= arr_data[cache_index];
         cache_rd_tag   <= arr_tag[cache_index];
         cache_rd_valid <= arr_val[cache_index];
      end
   end

   // timeline model: t counts cycles since the accept edge
   int          stall_cfg = 0;
   bit          busy = 0;
   int          t = 0, e_stall = 0, e_end = 0;
   bit          e_hit;
   logic [3:0]  e_idx, e_bval;
   logic [63:0] e_line;
   logic [31:0] e_addr, e_wdata;
   int          n_rd, n_wr, n_mem, n_ack, ack_t;
   logic [63:0] cap_wr_data;
   logic [31:0] cap_mem_addr;
   logic [3:0]  cap_mem_bval;

   initial begin
      logic [3:0]  exp_s;
      logic [63:0] mask, bm;
      int          sh;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
            chk("rst_outs", {sys_ack, cache_rd_en, cache_wr_en, mem_wr_req, |cache_index,
                             |cache_wr_data, |mem_addr, |mem_wdata, |mem_bval}, 64'd0);
         end else begin
            if (busy) t++;
            mem_ack = busy ? ((e_stall == 0) || (t >= 3 + e_stall)) : (stall_cfg == 0);
            if (!busy)                exp_s = 4'b0000;
            else if (e_bval == 4'b0)  exp_s = {t == 1, 3'b000};
            else exp_s = {t == 4 + e_stall, t == 1, (t == 2) && e_hit, (t >= 3) && (t <= 3 + e_stall)};
            chk("strobes", {sys_ack, cache_rd_en, cache_wr_en, mem_wr_req}, {60'd0, exp_s});
            if (busy) begin
               if (cache_rd_en) begin
                  n_rd++;
                  chk("rd_index", cache_index, e_idx);
               end
               if (cache_wr_en) begin
                  n_wr++;
                  cap_wr_data = cache_wr_data;
                  chk("wr_index", cache_index, e_idx);
                  chk("wr_data", cache_wr_data, e_line);
               end
               if (mem_wr_req) begin
                  n_mem++;
                  cap_mem_addr = mem_addr;
                  cap_mem_bval = mem_bval;
                  chk("mem_fields", {mem_addr, mem_wdata}, {e_addr, e_wdata});
                  chk("mem_bval", mem_bval, e_bval);
               end
               if (sys_ack) begin
                  n_ack++;
                  ack_t = t;
               end
            end
            if (busy && t == e_end) busy = 0;
            else if (!busy && sys_wr) begin
               busy    = 1;
               t       = 0;
               e_stall = stall_cfg;
               e_bval  = sys_bval;
               e_idx   = sys_addr[6:3];
               e_addr  = {sys_addr[31:2], 2'b00};
               e_wdata = sys_wdata;
               e_end   = (sys_bval == 4'b0) ? 1 : 4 + stall_cfg;
               e_hit   = arr_val[e_idx] && (arr_tag[e_idx] == sys_addr[31:7]);
               bm      = {32'd0, {8{sys_bval[3]}}, {8{sys_bval[2]}}, {8{sys_bval[1]}}, {8{sys_bval[0]}}};
               sh      = sys_addr[2] ? 32 : 0;
               mask    = bm << sh;
               e_line  = (arr_data[e_idx] & ~mask) | (({32'd0, sys_wdata} << sh) & mask);
               n_rd = 0; n_wr = 0; n_mem = 0; n_ack = 0; ack_t = -1;
            end
         end
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bv, input int stall);
      bit got = 0;
      stall_cfg = stall;
      @(posedge clk); #1;
      sys_addr = a; sys_wdata = d; sys_bval = bv; sys_wr = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (sys_ack) got = 1;
      end
      chk("ack_seen", got, 1);
      @(posedge clk); #1;
      sys_wr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         arr_data[i] = 64'(i); arr_tag[i] = '0; arr_val[i] = 1'b0;
      end
      arr_data[5] = 64'h1111_2222_3333_4444; arr_tag[5] = 25'd1; arr_val[5] = 1'b1;
      arr_data[9] = 64'hDEAD_BEEF_0000_1111; arr_tag[9] = 25'd1; arr_val[9] = 1'b0;
      #1;
      chk("reset_state", {sys_ack, cache_rd_en, cache_wr_en, mem_wr_req, cache_index, mem_addr}, 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // hit, low half
      do_write(32'h0000_00A8, 32'hAABBCCDD, 4'b0011, 0);
      chk("t1_wr_data", cap_wr_data, 64'h1111_2222_3333_CCDD);
      chk("t1_model", e_line, 64'h1111_2222_3333_CCDD);
      chk("t1_bval", cap_mem_bval, 4'b0011);
      chk("t1_latency", ack_t, 4);

      // hit, high half
      do_write(32'h0000_00AC, 32'hEE00_0000, 4'b1000, 0);
      chk("t2_wr_data", cap_wr_data, 64'hEE11_2222_3333_4444);
      chk("t2_mem_addr", cap_mem_addr, 32'h0000_00AC);

      // miss by tag, address LSBs set
      do_write(32'h0000_012F, 32'h0102_0304, 4'b0101, 0);
      chk("t3_no_wr", n_wr, 0);
      chk("t3_mem_addr", cap_mem_addr, 32'h0000_012C);
      chk("t3_latency", ack_t, 4);

      // miss by valid=0
      do_write(32'h0000_00C8, 32'h5555_6666, 4'b1111, 0);
      chk("t3b_no_wr", n_wr, 0);
      chk("t3b_mem", n_mem, 1);

      // memory stall
      do_write(32'h0000_00A8, 32'h1234_5678, 4'b1111, 5);
      chk("t4_latency", ack_t, 9);
      chk("t4_acks", n_ack, 1);
      chk("t4_mem_cycles", n_mem, 6);

      // empty byte mask
      do_write(32'h0000_00A8, 32'hFFFF_FFFF, 4'b0000, 0);
      chk("t5_latency", ack_t, 1);
      chk("t5_no_access", n_rd + n_wr + n_mem, 0);

      // reset while in MEM_WR
      stall_cfg = 50;
      @(posedge clk); #1;
      sys_addr = 32'h0000_00A8; sys_wdata = 32'h0BAD_F00D; sys_bval = 4'b1111; sys_wr = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      chk("t6_in_memwr", mem_wr_req, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_outs_zero", {sys_ack, mem_wr_req, cache_rd_en, cache_wr_en, mem_addr, mem_wdata}, 64'd0);
      sys_wr = 1'b0;
`ifdef CACHE_WR_STATS_EN
      chk("t6_stats_zero", {stat_hit_cnt, stat_miss_cnt}, 64'd0);
`endif
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_ack", sys_ack, 0);
      end
      @(posedge clk); #2 rst_n = 1'b1;

      do_write(32'h0000_00A8, 32'hAABBCCDD, 4'b0011, 0);
      chk("t6_clean_wr", cap_wr_data, 64'h1111_2222_3333_CCDD);
      chk("t6_clean_lat", ack_t, 4);
      do_write(32'h0000_00AC, 32'hEE00_0000, 4'b1000, 0);
      do_write(32'h0000_00AC, 32'h0000_0077, 4'b0001, 2);
      do_write(32'h0000_012F, 32'h0102_0304, 4'b0101, 0);
      do_write(32'h0000_00C8, 32'h5555_6666, 4'b1111, 1);
      do_write(32'h0000_00A8, 32'h0000_0000, 4'b0000, 0);
`ifdef CACHE_WR_STATS_EN
      chk("stat_hit", stat_hit_cnt, 16'd3);
      chk("stat_miss", stat_miss_cnt, 16'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
